// File: rtl/mul_out_ctrl_pipe.sv
// Multiplier output controller: per-element sign correction of raw unsigned
// products, then low/high half selection and packing, in a two-stage valid/ready pipe.
module mul_out_ctrl_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*XLEN-1:0]     in_product,
    input  logic [1:0]            in_opcode,
    input  logic [1:0]            in_precision,
    input  logic [XLEN/8-1:0]     in_sign_a,
    input  logic [XLEN/8-1:0]     in_sign_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic                  out_err
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned PW  = 2 * XLEN;
    localparam int unsigned N16 = NB / 2;
    localparam int unsigned N32 = NB / 4;
    localparam bit          W64_OK = (XLEN == 64);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] PREC_8    = 2'b00;
    localparam logic [1:0] PREC_16   = 2'b01;
    localparam logic [1:0] PREC_32   = 2'b10;
    localparam logic [1:0] PREC_64   = 2'b11;

    logic            s1_valid;
    logic [PW-1:0]   s1_prod;
    logic [1:0]      s1_opcode;
    logic [1:0]      s1_prec;
    logic            s1_err;

    logic            s1_ready_c;
    logic            s2_ready_c;
    logic [NB-1:0]   neg_c;
    logic            err_c;
    logic [PW-1:0]   corr_c;
    logic            sel_hi_c;
    logic [XLEN-1:0] sel_c;

    // Handshake: a stage accepts when empty or when its successor drains it.
    assign s2_ready_c = !out_valid || out_ready;
    assign s1_ready_c = !s1_valid || s2_ready_c;
    assign in_ready   = rst_n && s1_ready_c;

    assign neg_c = in_sign_a ^ in_sign_b;
    assign err_c = !W64_OK && (in_precision == PREC_64);

    // Lane-local two's complement; each slice negates independently so no carry crosses lanes.
    always_comb begin
        corr_c = in_product;
        case (in_precision)
            PREC_8: begin
                for (int e = 0; e < NB; e++) begin
                    if (neg_c[e]) corr_c[16*e +: 16] = 16'(~in_product[16*e +: 16] + 16'd1);
                end
            end
            PREC_16: begin
                for (int e = 0; e < N16; e++) begin
                    if (neg_c[e]) corr_c[32*e +: 32] = 32'(~in_product[32*e +: 32] + 32'd1);
                end
            end
            PREC_32: begin
                for (int e = 0; e < N32; e++) begin
                    if (neg_c[e]) corr_c[64*e +: 64] = 64'(~in_product[64*e +: 64] + 64'd1);
                end
            end
            default: begin
                if (neg_c[0]) corr_c = PW'(~in_product + PW'(1));
            end
        endcase
    end

    // Half selection and packing from the stage-1 product.
    always_comb begin
        sel_c    = '0;
        sel_hi_c = (s1_opcode != OP_MUL);
        case (s1_prec)
            PREC_8: begin
                for (int e = 0; e < NB; e++) begin
                    sel_c[8*e +: 8] = sel_hi_c ? s1_prod[16*e + 8 +: 8] : s1_prod[16*e +: 8];
                end
            end
            PREC_16: begin
                for (int e = 0; e < N16; e++) begin
                    sel_c[16*e +: 16] = sel_hi_c ? s1_prod[32*e + 16 +: 16] : s1_prod[32*e +: 16];
                end
            end
            PREC_32: begin
                for (int e = 0; e < N32; e++) begin
                    sel_c[32*e +: 32] = sel_hi_c ? s1_prod[64*e + 32 +: 32] : s1_prod[64*e +: 32];
                end
            end
            default: begin
                if (!s1_err) sel_c = sel_hi_c ? s1_prod[PW-1 -: XLEN] : s1_prod[XLEN-1:0];
            end
        endcase
    end

    // Stage 1: sign-corrected product and control.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_opcode <= '0;
            s1_prec   <= '0;
            s1_err    <= 1'b0;
        end else if (s1_ready_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_prod   <= err_c ? '0 : corr_c;
                s1_opcode <= in_opcode;
                s1_prec   <= in_precision;
                s1_err    <= err_c;
            end
        end
    end

    // Stage 2: packed result; holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (s2_ready_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sel_c;
                out_err  <= s1_err;
            end
        end
    end

endmodule

// File: tb/tb_mul_out_ctrl_pipe.sv
// Directed bench for mul_out_ctrl_pipe at XLEN=32 with hand-computed expectations.
module tb_mul_out_ctrl_pipe;

    localparam int unsigned XLEN = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2*XLEN-1:0] in_product;
    logic [1:0]        in_opcode;
    logic [1:0]        in_precision;
    logic [3:0]        in_sign_a;
    logic [3:0]        in_sign_b;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_data;
    logic              out_err;

    int checks = 0;
    int errors = 0;

    mul_out_ctrl_pipe #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_opcode    (in_opcode),
        .in_precision (in_precision),
        .in_sign_a    (in_sign_a),
        .in_sign_b    (in_sign_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] prod, input logic [1:0] op, input logic [1:0] prec,
                         input logic [3:0] sa, input logic [3:0] sb);
        in_product   = prod;
        in_opcode    = op;
        in_precision = prec;
        in_sign_a    = sa;
        in_sign_b    = sb;
    endtask

    // One isolated transaction: checks exact two-edge latency and the result.
    task automatic run1(input string tag, input logic [63:0] prod, input logic [1:0] op,
                        input logic [1:0] prec, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [31:0] exp_data, input logic exp_err);
        drive(prod, op, prec, sa, sb);
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(exp_data));
        chk({tag, "_err"}, 64'(out_err), 64'(exp_err));
        step();
        chk({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(64'd0, 2'b00, 2'b00, 4'd0, 4'd0);

        // Reset state
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_in_ready_low", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        step();

        // Sign correction and half selection
        run1("w32_lo_neg", 64'h6, 2'b00, 2'b10, 4'b0001, 4'b0000, 32'hFFFF_FFFA, 1'b0);
        run1("w32_hi_neg", 64'h6, 2'b01, 2'b10, 4'b0001, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        run1("w32_both_sign", 64'h6, 2'b00, 2'b10, 4'b0001, 4'b0001, 32'h0000_0006, 1'b0);
        run1("w32_ign_slots", 64'h6, 2'b01, 2'b10, 4'b1110, 4'b0000, 32'h0000_0000, 1'b0);
        run1("w8_lane0_neg", 64'h10, 2'b00, 2'b00, 4'b0001, 4'b0000, 32'h0000_00F0, 1'b0);
        run1("w8_lane2_hi", 64'h0000_0003_0000_0000, 2'b11, 2'b00, 4'b0000, 4'b0100,
             32'h00FF_0000, 1'b0);
        run1("w16_hi", 64'h0000_0001_0000_0002, 2'b10, 2'b01, 4'b0000, 4'b0000,
             32'h0000_0000, 1'b0);
        run1("w16_lo", 64'h0000_0001_0000_0002, 2'b00, 2'b01, 4'b0000, 4'b0000,
             32'h0001_0002, 1'b0);
        run1("w16_lane1_neg", 64'h0000_0001_0000_0002, 2'b00, 2'b01, 4'b0000, 4'b0010,
             32'hFFFF_0002, 1'b0);
        run1("prec64_err", 64'h1234_5678_9ABC_DEF0, 2'b00, 2'b11, 4'b0001, 4'b0000,
             32'h0000_0000, 1'b1);
        run1("after_err", 64'h6, 2'b00, 2'b10, 4'b0001, 4'b0000, 32'hFFFF_FFFA, 1'b0);

        // Backpressure: three back-to-back with out_ready low
        out_ready = 1'b0;
        drive(64'd1, 2'b00, 2'b10, 4'd0, 4'd0);
        in_valid = 1'b1;
        #1;
        chk("bp_rdy_a", 64'(in_ready), 64'd1);
        step();
        drive(64'd2, 2'b00, 2'b10, 4'd0, 4'd0);
        #1;
        chk("bp_rdy_b", 64'(in_ready), 64'd1);
        step();
        drive(64'd3, 2'b00, 2'b10, 4'd0, 4'd0);
        #1;
        chk("bp_rdy_full", 64'(in_ready), 64'd0);
        chk("bp_valid_a", 64'(out_valid), 64'd1);
        chk("bp_data_a", 64'(out_data), 64'd1);
        step();
        chk("bp_hold_data1", 64'(out_data), 64'd1);
        chk("bp_hold_rdy1", 64'(in_ready), 64'd0);
        step();
        chk("bp_hold_data2", 64'(out_data), 64'd1);
        chk("bp_hold_valid2", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_valid_b", 64'(out_valid), 64'd1);
        chk("bp_data_b", 64'(out_data), 64'd2);
        step();
        chk("bp_valid_c", 64'(out_valid), 64'd1);
        chk("bp_data_c", 64'(out_data), 64'd3);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Reset with two transactions in flight
        out_ready = 1'b0;
        drive(64'd7, 2'b00, 2'b10, 4'd0, 4'd0);
        in_valid = 1'b1;
        step();
        drive(64'd8, 2'b00, 2'b10, 4'd0, 4'd0);
        step();
        in_valid = 1'b0;
        chk("flight_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_rdy", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_emit", 64'(out_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
